utf16_encoder: RTL and testbench

UTF16_ENCODER -- requirements
Module: utf16_encoder

---
 rtl/utf16_encoder_if.sv | 22 ++
 rtl/utf16_encoder.sv | 111 +++++++++++
 tb/tb_utf16_encoder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/utf16_encoder_if.sv
// Handshake bundle for utf16_encoder: decoder-side offer, UTF-16 unit stream and error status.
interface utf16_encoder_if;
    logic        in_valid;
    logic [2:0]  status;
    logic [20:0] codepoint;
    logic        in_ready;
    logic [15:0] unit;
    logic        unit_valid;
    logic        unit_ready;
    logic        error;
    logic [7:0]  error_count;

    modport master (
        output in_valid, status, codepoint, unit_ready,
        input  in_ready, unit, unit_valid, error, error_count
    );

    modport slave (
        input  in_valid, status, codepoint, unit_ready,
        output in_ready, unit, unit_valid, error, error_count
    );
endinterface

// File: rtl/utf16_encoder.sv
// Converts decoded Unicode scalars into a UTF-16 code-unit stream with surrogate pairing.
// Define UTF16_ENCODER_REPLACEMENT_EN to emit U+FFFD for every accepted error.
module utf16_encoder (
    input logic            clock,
    input logic            reset,
    utf16_encoder_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, PAIR} state_t;

    state_t      state_q, state_n;
    logic [15:0] unit_q, unit_n;
    logic [15:0] low_q, low_n;
    logic        error_q, error_n;
    logic [7:0]  count_q, count_n;

    logic [2:0]  status_eff;
    logic        is_scalar, in_surrogate, is_bmp, is_supp, is_err;
    logic [19:0] offset;
    logic        accept, transfer;
    logic        prod_one;
    logic [15:0] one_value;

    // Reserved status codes 5-7 are folded onto idle.
    assign status_eff   = (bus.status > 3'd4) ? 3'd0 : bus.status;
    assign is_scalar    = (status_eff == 3'd2);
    assign in_surrogate = (bus.codepoint >= 21'h00D800) && (bus.codepoint <= 21'h00DFFF);
    assign is_bmp       = is_scalar && (bus.codepoint <= 21'h00FFFF) && !in_surrogate;
    assign is_supp      = is_scalar && (bus.codepoint >= 21'h010000) && (bus.codepoint <= 21'h10FFFF);
    assign is_err       = (status_eff == 3'd3) || (status_eff == 3'd4) ||
                          (is_scalar && !is_bmp && !is_supp);
    // Modulo-2^20 subtraction yields the correct offset for the whole supplementary range.
    assign offset       = bus.codepoint[19:0] - 20'h10000;

`ifdef UTF16_ENCODER_REPLACEMENT_EN
    assign prod_one  = is_bmp || is_err;
    assign one_value = is_err ? 16'hFFFD : bus.codepoint[15:0];
`else
    assign prod_one  = is_bmp;
    assign one_value = bus.codepoint[15:0];
`endif

    always_comb begin
        bus.in_ready = 1'b0;
        case (state_q)
            EMPTY:   bus.in_ready = 1'b1;
            ONE:     bus.in_ready = bus.unit_ready;
            default: bus.in_ready = 1'b0;
        endcase
    end

    assign bus.unit_valid  = (state_q != EMPTY);
    assign bus.unit        = unit_q;
    assign bus.error       = error_q;
    assign bus.error_count = count_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign transfer = bus.unit_valid && bus.unit_ready;

    always_comb begin
        state_n = state_q;
        unit_n  = unit_q;
        low_n   = low_q;
        case (state_q)
            EMPTY, ONE: begin
                if (state_q == ONE && transfer)
                    state_n = EMPTY;
                // In ONE an accept implies a transfer, so a new unit replaces the old with no bubble.
                if (accept) begin
                    if (is_supp) begin
                        state_n = PAIR;
                        unit_n  = {6'b110110, offset[19:10]};
                        low_n   = {6'b110111, offset[9:0]};
                    end else if (prod_one) begin
                        state_n = ONE;
                        unit_n  = one_value;
                    end
                end
            end
            PAIR: begin
                if (transfer) begin
                    state_n = ONE;
                    unit_n  = low_q;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_comb begin
        error_n = accept && is_err;
        count_n = count_q;
        if (error_n && count_q != 8'hFF)
            count_n = count_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            unit_q  <= '0;
            low_q   <= '0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            unit_q  <= unit_n;
            low_q   <= low_n;
            error_q <= error_n;
            count_q <= count_n;
        end
    end
endmodule

// File: tb/tb_utf16_encoder.sv
// Scoreboard bench for utf16_encoder: directed scenarios plus randomized traffic against a reference model.
module tb_utf16_encoder;
    logic clock = 1'b0;
    logic reset = 1'b1;

    utf16_encoder_if bus();

    utf16_encoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int model_cnt = 0;
    logic [15:0] exp_units[$];
    logic [8:0]  exp_err[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: UTF-16 rules applied directly to the scalar value.
    task automatic model_accept(input logic [2:0] st, input logic [20:0] cp, output logic err);
        int s, c, v;
        s = (st > 3'd4) ? 0 : int'(st);
        c = int'(cp);
        err = 1'b0;
        if (s == 2) begin
            if (c < 'h10000 && (c < 'hD800 || c > 'hDFFF)) begin
                exp_units.push_back(16'(c));
            end else if (c >= 'h10000 && c <= 'h10FFFF) begin
                v = c - 'h10000;
                exp_units.push_back(16'('hD800 + v / 1024));
                exp_units.push_back(16'('hDC00 + v % 1024));
            end else begin
                err = 1'b1;
            end
        end else if (s == 3 || s == 4) begin
            err = 1'b1;
        end
        if (err) begin
            if (model_cnt < 255) model_cnt++;
`ifdef UTF16_ENCODER_REPLACEMENT_EN
            exp_units.push_back(16'hFFFD);
`endif
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] st, input logic [20:0] cp, input logic ur);
        logic err;
        @(negedge clock);
        bus.in_valid   = v;
        bus.status     = st;
        bus.codepoint  = cp;
        bus.unit_ready = ur;
        #1;
        err = 1'b0;
        if (bus.in_valid && bus.in_ready) model_accept(st, cp, err);
        exp_err.push_back({err, 8'(model_cnt)});
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.status     = '0;
        bus.codepoint  = '0;
        bus.unit_ready = 1'b0;
        exp_units.delete();
        exp_err.delete();
        model_cnt = 0;
        @(negedge clock);
        #1;
        check("rst_unit_valid", 32'(bus.unit_valid), 32'd0);
        check("rst_unit", 32'(bus.unit), 32'h0000);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_error_count", 32'(bus.error_count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;
    endtask

    // Monitor: consumes expectations whenever the DUT transfers a unit or a cycle's error status matures.
    always begin
        logic [8:0] e;
        @(negedge clock);
        #2;
        if (!reset) begin
            if (bus.unit_valid && bus.unit_ready) begin
                if (exp_units.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_unit: got %h expected none at %0t", bus.unit, $time);
                end else begin
                    check("unit", 32'(bus.unit), 32'(exp_units.pop_front()));
                end
            end
            if (exp_err.size() >= 2) begin
                e = exp_err.pop_front();
                check("error", 32'(bus.error), 32'(e[8]));
                check("error_count", 32'(bus.error_count), 32'(e[7:0]));
            end
        end
    end

    initial begin
        logic [20:0] cp;
        bus.in_valid   = 1'b0;
        bus.status     = '0;
        bus.codepoint  = '0;
        bus.unit_ready = 1'b0;
        do_reset();

        // Latency-1 BMP unit, then drain to EMPTY.
        drive(1'b1, 3'd2, 21'h000041, 1'b0);
        drive(1'b0, 3'd0, 21'h0, 1'b1);
        check("bmp_latency_unit", 32'(bus.unit), 32'h0041);
        drive(1'b0, 3'd0, 21'h0, 1'b0);
        check("bmp_drained", 32'(bus.unit_valid), 32'd0);

        // Surrogate pairs with in_ready low while the high half is held.
        drive(1'b1, 3'd2, 21'h01F600, 1'b0);
        drive(1'b1, 3'd2, 21'h000041, 1'b0);
        check("pair_in_ready", 32'(bus.in_ready), 32'd0);
        check("pair_high", 32'(bus.unit), 32'hD83D);
        drive(1'b0, 3'd0, 21'h0, 1'b1);
        drive(1'b1, 3'd2, 21'h10FFFF, 1'b1);
        drive(1'b0, 3'd0, 21'h0, 1'b0);
        check("max_high", 32'(bus.unit), 32'hDBFF);
        drive(1'b0, 3'd0, 21'h0, 1'b1);
        drive(1'b0, 3'd0, 21'h0, 1'b1);

        // Error responses: bad continuation and a lone surrogate scalar.
        drive(1'b1, 3'd4, 21'h0, 1'b1);
        drive(1'b0, 3'd0, 21'h0, 1'b1);
        check("err4_pulse", 32'(bus.error), 32'd1);
        check("err4_count", 32'(bus.error_count), 32'd1);
`ifdef UTF16_ENCODER_REPLACEMENT_EN
        check("err4_unit", 32'(bus.unit), 32'hFFFD);
`else
        check("err4_no_unit", 32'(bus.unit_valid), 32'd0);
`endif
        drive(1'b1, 3'd2, 21'h00D800, 1'b1);
        drive(1'b0, 3'd0, 21'h0, 1'b1);
        check("errsurr_pulse", 32'(bus.error), 32'd1);
        check("errsurr_count", 32'(bus.error_count), 32'd2);
        drive(1'b0, 3'd0, 21'h0, 1'b1);
        check("err_one_cycle", 32'(bus.error), 32'd0);

        // Back-pressure hold, then release with a simultaneous accept.
        drive(1'b1, 3'd2, 21'h0020AC, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd2, 21'h000041, 1'b0);
            check("hold_unit", 32'(bus.unit), 32'h20AC);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        drive(1'b1, 3'd2, 21'h000041, 1'b1);
        drive(1'b0, 3'd0, 21'h0, 1'b0);
        check("nobubble_valid", 32'(bus.unit_valid), 32'd1);
        check("nobubble_unit", 32'(bus.unit), 32'h0041);
        drive(1'b0, 3'd0, 21'h0, 1'b1);

        // Reset while a low surrogate is pending discards it.
        drive(1'b1, 3'd2, 21'h01F600, 1'b0);
        drive(1'b0, 3'd0, 21'h0, 1'b0);
        check("prereset_pair", 32'(bus.unit), 32'hD83D);
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 21'h0, 1'b1);
        check("postreset_empty", 32'(bus.unit_valid), 32'd0);

        // Randomized traffic over all status codes and codepoint classes.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: cp = 21'($urandom_range(0, 'hFFFF));
                1: cp = 21'($urandom_range('hD800, 'hDFFF));
                2: cp = 21'($urandom_range('h10000, 'h10FFFF));
                default: cp = 21'($urandom_range('h110000, 'h1FFFFF));
            endcase
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), cp,
                  1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 8; i++) drive(1'b0, 3'd0, 21'h0, 1'b1);
        check("random_drained", 32'(exp_units.size()), 32'd0);

        // Error counter saturation.
        do_reset();
        for (int i = 0; i < 260; i++) drive(1'b1, 3'd3, 21'h0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 21'h0, 1'b1);
        check("sat_count", 32'(bus.error_count), 32'hFF);
        check("sat_drained", 32'(exp_units.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
